// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and default frame geometry
// used by both the RX and TX sides.
package uart_pkg;

    localparam int unsigned UART_BAUD_DIV  = 16;
    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned BIT_IDX_W      = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_bit_timer.sv
// Bit-period counter: cleared by load, advanced by run, wraps at BAUD_DIV-1.
// Emits combinational half-period and full-period tick strobes.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = UART_BAUD_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic half_tick_c,
    output logic full_tick_c
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] baud_cnt;

    assign half_tick_c = (baud_cnt == HALF_LAST);
    assign full_tick_c = (baud_cnt == FULL_LAST);

    // Counter never passes BAUD_DIV-1; it restarts from zero on the full tick.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            baud_cnt <= '0;
        end else if (run) begin
            baud_cnt <= full_tick_c ? '0 : baud_cnt + CNT_W'(1);
        end
    end

endmodule : uart_bit_timer

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: line synchronizer, start-bit qualification, mid-bit
// shift strobes, stop/parity checks and sticky interrupt. Parity: UART_RX_PARITY_EN.
module uart_rx_sequencer
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV  = UART_BAUD_DIV,
    parameter int unsigned DATA_BITS = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_data,
    input  logic                 clear_interrupt,
    output logic                 shift_en,
    output logic                 sample_bit,
    output logic [BIT_IDX_W-1:0] bit_idx,
    output logic                 frame_done,
    output logic                 framing_err,
    output logic                 parity_err,
    output logic                 interrupt,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    logic                 sync_ff;
    logic                 rx_s;
    logic                 rx_q;
    rx_state_t            state_q;
    rx_state_t            state_d;
    logic [BIT_IDX_W-1:0] bit_cnt_q;
    logic [BIT_IDX_W-1:0] bit_cnt_d;
    logic                 timer_load_c;
    logic                 timer_run_c;
    logic                 half_tick_c;
    logic                 full_tick_c;
    logic                 shift_en_d;
    logic                 sample_bit_d;
    logic [BIT_IDX_W-1:0] bit_idx_d;
    logic                 frame_done_d;
    logic                 framing_err_d;
    logic                 busy_d;
`ifdef UART_RX_PARITY_EN
    logic                 parity_acc_q;
    logic                 parity_acc_d;
    logic                 parity_err_d;
`endif

    uart_bit_timer #(
        .BAUD_DIV    (BAUD_DIV)
    ) u_bit_timer (
        .clk         (clk),
        .rst         (rst),
        .load        (timer_load_c),
        .run         (timer_run_c),
        .half_tick_c (half_tick_c),
        .full_tick_c (full_tick_c)
    );

    // Two-flop synchronizer plus edge register; idle-high reset avoids a false start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            sync_ff <= rx_data;
            rx_s    <= sync_ff;
            rx_q    <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Next-state and registered-output inputs
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        timer_load_c  = 1'b0;
        timer_run_c   = 1'b0;
        shift_en_d    = 1'b0;
        sample_bit_d  = sample_bit;
        bit_idx_d     = bit_idx;
        frame_done_d  = 1'b0;
        framing_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_acc_d  = parity_acc_q;
        parity_err_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                timer_load_c = 1'b1;
                if (rx_q && !rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                timer_run_c = 1'b1;
                if (half_tick_c) begin
                    timer_load_c = 1'b1;
                    if (!rx_s) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        parity_acc_d = 1'b0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                timer_run_c = 1'b1;
                if (full_tick_c) begin
                    shift_en_d   = 1'b1;
                    sample_bit_d = rx_s;
                    bit_idx_d    = bit_cnt_q;
`ifdef UART_RX_PARITY_EN
                    parity_acc_d = parity_acc_q ^ rx_s;
`endif
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_IDX_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                timer_run_c = 1'b1;
                if (full_tick_c) begin
                    parity_acc_d = parity_acc_q ^ rx_s;
                    state_d      = STOP;
                end
            end
`endif
            STOP: begin
                timer_run_c = 1'b1;
                if (full_tick_c) begin
                    frame_done_d  = 1'b1;
                    framing_err_d = !rx_s;
`ifdef UART_RX_PARITY_EN
                    parity_err_d  = parity_acc_q;
`endif
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_en    <= 1'b0;
            sample_bit  <= 1'b0;
            bit_idx     <= '0;
            frame_done  <= 1'b0;
            framing_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            shift_en    <= shift_en_d;
            sample_bit  <= sample_bit_d;
            bit_idx     <= bit_idx_d;
            frame_done  <= frame_done_d;
            framing_err <= framing_err_d;
            busy        <= busy_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_acc_q <= 1'b0;
            parity_err   <= 1'b0;
        end else begin
            parity_acc_q <= parity_acc_d;
            parity_err   <= parity_err_d;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // Sticky flags: a completing frame beats a simultaneous clear for interrupt,
    // while the clear suppresses overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            interrupt <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_done) begin
                interrupt <= 1'b1;
            end else if (clear_interrupt) begin
                interrupt <= 1'b0;
            end
            if (clear_interrupt) begin
                overrun <= 1'b0;
            end else if (frame_done && interrupt) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule : uart_rx_sequencer

// File: tb/tb_uart_rx_sequencer.sv
// Self-checking bench for uart_rx_sequencer: table-driven frames with a bit/frame
// scoreboard, plus hand-written glitch, break, overrun, clear and reset sequences.
module tb_uart_rx_sequencer;

    localparam int unsigned D  = 16;
    localparam int unsigned NB = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif
    localparam int unsigned FD_GAP = PAR_ON ? 2 * D : D;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_data;
    logic       clear_interrupt;
    logic       shift_en;
    logic       sample_bit;
    logic [3:0] bit_idx;
    logic       frame_done;
    logic       framing_err;
    logic       parity_err;
    logic       interrupt;
    logic       overrun;
    logic       busy;

    uart_rx_sequencer #(
        .BAUD_DIV        (D),
        .DATA_BITS       (NB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_data         (rx_data),
        .clear_interrupt (clear_interrupt),
        .shift_en        (shift_en),
        .sample_bit      (sample_bit),
        .bit_idx         (bit_idx),
        .frame_done      (frame_done),
        .framing_err     (framing_err),
        .parity_err      (parity_err),
        .interrupt       (interrupt),
        .overrun         (overrun),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       bit_v;
        logic [3:0] idx;
    } bit_exp_t;

    typedef struct {
        logic ferr;
        logic perr;
    } frm_exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       par_bit;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    bit_exp_t bit_q[$];
    frm_exp_t frm_q[$];
    vec_t     tbl[7];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic exp_par_err(input logic [7:0] d, input logic p);
        return PAR_ON & ((^d) ^ p);
    endfunction

    // Scoreboard monitor: pops expectations when the DUT strobes.
    int unsigned cyc = 0;
    int unsigned last_shift = 0;
    logic        prev_fd = 1'b0;
    always @(negedge clk) begin
        bit_exp_t be;
        frm_exp_t fe;
        cyc++;
        if (!rst) begin
            if (shift_en) begin
                chk("shift_en_expected", int'(bit_q.size() > 0), 1);
                if (bit_q.size() > 0) begin
                    be = bit_q.pop_front();
                    chk("sample_bit", int'(sample_bit), int'(be.bit_v));
                    chk("bit_idx", int'(bit_idx), int'(be.idx));
                    if (be.idx != 4'd0) chk("shift_spacing", int'(cyc - last_shift), int'(D));
                end
                last_shift = cyc;
            end
            if (frame_done) begin
                chk("frame_done_expected", int'(frm_q.size() > 0), 1);
                if (frm_q.size() > 0) begin
                    fe = frm_q.pop_front();
                    chk("framing_err", int'(framing_err), int'(fe.ferr));
                    chk("parity_err", int'(parity_err), int'(fe.perr));
                    chk("frame_done_gap", int'(cyc - last_shift), int'(FD_GAP));
                end
            end else if (prev_fd) begin
                chk("errs_after_frame_done", int'({framing_err, parity_err}), 0);
            end
        end
        prev_fd = frame_done;
    end

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_bit,
                              input logic exp_ferr, input logic exp_perr, input int break_cyc);
        for (int i = 0; i < int'(NB); i++) bit_q.push_back('{data[i], 4'(i)});
        frm_q.push_back('{exp_ferr, exp_perr});
        rx_data = 1'b0;
        wait_cyc(D);
        for (int i = 0; i < int'(NB); i++) begin
            rx_data = data[i];
            wait_cyc(D);
        end
        if (PAR_ON) begin
            rx_data = par_bit;
            wait_cyc(D);
        end
        rx_data = stop_bit;
        wait_cyc(D);
        if (break_cyc > 0) begin
            rx_data = 1'b0;
            wait_cyc(break_cyc);
        end
        rx_data = 1'b1;
        wait_cyc(4);
    endtask

    task automatic good_frame(input logic [7:0] data);
        send_frame(data, 1'b1, ^data, 1'b0, 1'b0, 0);
    endtask

    task automatic pulse_clear();
        clear_interrupt = 1'b1;
        wait_cyc(1);
        clear_interrupt = 1'b0;
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b0};
        foreach (tbl[i]) tbl[i].exp_perr = exp_par_err(tbl[i].data, tbl[i].par_bit);

        rst = 1'b1;
        rx_data = 1'b1;
        clear_interrupt = 1'b0;
        wait_cyc(4);
        chk("rst_shift_en", int'(shift_en), 0);
        chk("rst_sample_bit", int'(sample_bit), 0);
        chk("rst_bit_idx", int'(bit_idx), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_framing_err", int'(framing_err), 0);
        chk("rst_parity_err", int'(parity_err), 0);
        chk("rst_interrupt", int'(interrupt), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        wait_cyc(4);
        chk("idle_busy", int'(busy), 0);

        // Table-driven frames
        for (int i = 0; i < 7; i++) begin
            send_frame(tbl[i].data, tbl[i].stop_bit, tbl[i].par_bit,
                       tbl[i].exp_ferr, tbl[i].exp_perr, 0);
            chk($sformatf("tbl%0d_interrupt", i), int'(interrupt), 1);
            chk($sformatf("tbl%0d_overrun", i), int'(overrun), 0);
            pulse_clear();
            chk($sformatf("tbl%0d_cleared", i), int'(interrupt), 0);
        end

        // Short low glitch: false start, back to idle with no strobes
        rx_data = 1'b0;
        wait_cyc(3);
        chk("glitch_busy_high", int'(busy), 1);
        wait_cyc(1);
        rx_data = 1'b1;
        wait_cyc(D / 2 + 4);
        chk("glitch_busy_low", int'(busy), 0);
        chk("glitch_no_interrupt", int'(interrupt), 0);

        // Framing error followed by a break: no new frame until the line goes high
        send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3 * D);
        chk("break_busy", int'(busy), 0);
        chk("break_queue", int'(bit_q.size()), 0);
        good_frame(8'h81);
        chk("after_break_queue", int'(frm_q.size()), 0);
        pulse_clear();

        // Overrun on a second unacknowledged frame
        good_frame(8'hA5);
        chk("ovr_first_overrun", int'(overrun), 0);
        good_frame(8'h3C);
        chk("ovr_second_overrun", int'(overrun), 1);
        chk("ovr_second_interrupt", int'(interrupt), 1);
        pulse_clear();
        chk("ovr_clear_interrupt", int'(interrupt), 0);
        chk("ovr_clear_overrun", int'(overrun), 0);

        // clear_interrupt coincident with frame_done
        good_frame(8'h55);
        fork
            good_frame(8'hC3);
            begin : poll
                logic got;
                got = 1'b0;
                for (int k = 0; k < 400 && !got; k++) begin
                    @(negedge clk);
                    if (frame_done) begin
                        clear_interrupt = 1'b1;
                        got = 1'b1;
                    end
                end
                chk("same_cycle_seen", int'(got), 1);
                @(negedge clk);
                clear_interrupt = 1'b0;
                chk("same_cycle_interrupt", int'(interrupt), 1);
                chk("same_cycle_overrun", int'(overrun), 0);
            end
        join

        // Reset during data bit 3 aborts the frame
        bit_q.push_back('{1'b1, 4'd0});
        bit_q.push_back('{1'b1, 4'd1});
        bit_q.push_back('{1'b1, 4'd2});
        rx_data = 1'b0;
        wait_cyc(D);
        for (int i = 0; i < 3; i++) begin
            rx_data = 1'b1;
            wait_cyc(D);
        end
        rx_data = 1'b1;
        wait_cyc(2);
        chk("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_shift_en", int'(shift_en), 0);
        chk("mid_rst_bit_idx", int'(bit_idx), 0);
        chk("mid_rst_frame_done", int'(frame_done), 0);
        chk("mid_rst_interrupt", int'(interrupt), 0);
        wait_cyc(2 * D);
        chk("post_rst_idle", int'(busy), 0);
        chk("post_rst_bits_drained", int'(bit_q.size()), 0);
        good_frame(8'h5A);
        chk("post_rst_interrupt", int'(interrupt), 1);

        wait_cyc(4);
        chk("final_bit_queue", int'(bit_q.size()), 0);
        chk("final_frame_queue", int'(frm_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_uart_rx_sequencer

// File: doc/uart_rx_sequencer.md
# uart_rx_sequencer

Control block that sequences the UART receive datapath. Synchronizes the serial line, detects and qualifies the start bit, and times mid-bit samples. It emits per-bit shift strobes to the receive shift register, checks the stop bit (and optionally parity), and keeps a sticky interrupt with overrun detection. It sits between the `rx_data` pin and the receive shift/data registers, and its interrupt feeds the core's interrupt logic.

## Interface
- `BAUD_DIV`, 16: clock cycles per bit period; legal range 4..65535.
- `DATA_BITS`, 8: data bits per frame; legal range 5..9.
- `clk`  in  1  single system clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  1  asynchronous serial line; idle high.
- `clear_interrupt`  in  1  one-cycle pulse that clears `interrupt` and `overrun`.
- `shift_en`  out  1  one-cycle strobe; the shift register captures `sample_bit`.
- `sample_bit`  out  1  synchronized line value at the sample instant.
- `bit_idx`  out  4  index of the data bit being strobed (0 = LSB).
- `frame_done`  out  1  one-cycle pulse at the stop-bit sample.
- `framing_err`  out  1  valid with `frame_done`; stop bit sampled low.
- `parity_err`  out  1  valid with `frame_done`; tied 0 when parity is compiled out.
- `interrupt`  out  1  sticky; set on `frame_done`.
- `overrun`  out  1  sticky; set on `frame_done` while `interrupt` is already 1.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Two-flop synchronizer on `rx_data` produces `rx_s`. A third flop holds `rx_q` for edge detection.
- States: IDLE, START, DATA, PARITY (only when the macro is defined), STOP.
- IDLE: when `rx_q`=1 and `rx_s`=0, go to START and set `baud_cnt`=0.
- START: count to `BAUD_DIV/2 - 1`, then sample.
  - `rx_s`=0: go to DATA, `baud_cnt`=0, `bit_idx`=0.
  - `rx_s`=1: false start; return to IDLE with no strobes.
- DATA: at `baud_cnt`=`BAUD_DIV-1`, pulse `shift_en` with `sample_bit`=`rx_s`, reset `baud_cnt`, and increment `bit_idx`. After the strobe for `bit_idx`=`DATA_BITS-1`, go to PARITY or STOP.
- PARITY: sample at `BAUD_DIV-1`, then go to STOP.
- STOP: sample at `BAUD_DIV-1`, pulse `frame_done`, set `framing_err` = !`rx_s`, and return to IDLE.
  - A break (line held low) produces no new frame until a 1→0 edge occurs.
- `interrupt`/`overrun` update on `frame_done`:
  - `overrun` is set if `interrupt` was already 1.
  - `clear_interrupt` clears both.
  - If `clear_interrupt` and `frame_done` arrive in the same cycle, set wins for `interrupt` and `overrun` is not set.
- `baud_cnt` width is `$clog2(BAUD_DIV)`. It never wraps past `BAUD_DIV-1`.
- `rx_data` edges outside IDLE are ignored.

## Timing
- Reset values: state IDLE, counters 0, and every output 0 except `bit_idx`=0. The synchronizer flops reset to 1.
- Reset asserted mid-frame aborts the frame immediately. The next cycle is IDLE with no `frame_done`.
- Line-to-detection latency: 2 cycles (synchronizer) plus 1 cycle (edge register).
- Detection to first `shift_en`: `BAUD_DIV/2 + BAUD_DIV` cycles.
- Successive `shift_en` pulses are exactly `BAUD_DIV` cycles apart.
- `frame_done` follows the last data `shift_en` by `BAUD_DIV` cycles, or by 2×`BAUD_DIV` with parity.
- `frame_done`, `framing_err` and `parity_err` are registered and valid in the same cycle. Both error flags are 0 outside `frame_done`.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state exists.
  - Even parity is accumulated over all data samples plus the parity sample.
  - `parity_err` = accumulated XOR ≠ 0.
- `UART_RX_PARITY_EN` not defined:
  - DATA goes directly to STOP.
  - `parity_err` is constant 0.
  - No parity flop is synthesized.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `rx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - default `BAUD_DIV` and `DATA_BITS` constants, reused by the TX side.
- Sub-module `uart_bit_timer` holds `baud_cnt`:
  - inputs: load (clear) and run;
  - output: half-tick and full-tick strobes for a given `BAUD_DIV`.
- The FSM, synchronizer and interrupt logic stay in `uart_rx_sequencer`.

## Test plan
- Frame 0xA5 (`BAUD_DIV`=16, `DATA_BITS`=8, stop=1):
  - eight `shift_en` pulses 16 cycles apart;
  - `sample_bit` sequence 1,0,1,0,0,1,0,1;
  - `frame_done` with both errors 0;
  - `interrupt`=1.
- Low glitch of 4 cycles in IDLE → return to IDLE; no `shift_en`, no `frame_done`, `busy` low again after the half period.
- Frame 0x3C with stop bit driven 0 → `frame_done` with `framing_err`=1. The next frame is accepted only after the line returns high.
- Two frames, no `clear_interrupt` → `overrun`=1 at the second `frame_done`. `clear_interrupt` then clears both flags.
- `clear_interrupt` in the same cycle as `frame_done` → `interrupt`=1, `overrun`=0.
- `rst` pulsed at data bit 3 → outputs at reset values next cycle; no `frame_done`. A following 0x5A frame is received correctly.
- With `UART_RX_PARITY_EN` defined, 0x07 plus parity bit 0 → `parity_err`=1 (0x07 has three set bits, so even parity requires 1).
